// File: rtl/csr_weight_packer.sv
// csr_weight_packer: packs dense row-major weights into CSR words {col, weight},
// skipping zeros, and emits one cumulative row-end pointer per row.
module csr_weight_packer #(
    parameter int ADDR_W   = 14,
    parameter int IDX_W    = 10,
    parameter int W_W      = 8,
    parameter int NUM_ROWS = 16,
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W_W-1:0]         in_weight,
    input  logic                   in_last,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [IDX_W+W_W-1:0]   mem_wdata,
    output logic                   ptr_we,
    output logic [ROW_W-1:0]       ptr_addr,
    output logic [ADDR_W:0]        ptr_data,
    output logic                   done,
    output logic                   err
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [IDX_W+W_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   ptr_we_q, ptr_we_d;
    logic [ROW_W-1:0]       ptr_addr_q, ptr_addr_d;
    logic [ADDR_W:0]        ptr_data_q, ptr_data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic beat_acc;
    logic nonzero;
    logic full;

    assign in_ready  = (state_q == S_PACK);
    assign beat_acc  = in_valid && in_ready;
    assign nonzero   = (in_weight != '0);
    assign full      = wr_ptr_q[ADDR_W];

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ptr_we    = ptr_we_q;
    assign ptr_addr  = ptr_addr_q;
    assign ptr_data  = ptr_data_q;
    assign done      = done_q;
    assign err       = err_q;

    // Next-state logic: job control, zero skipping, row pointers and fault detection.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        col_d       = col_q;
        row_d       = row_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ptr_we_d    = 1'b0;
        ptr_addr_d  = ptr_addr_q;
        ptr_data_d  = ptr_data_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_PACK: begin
                if (beat_acc) begin
                    if (nonzero && full) begin
                        // No room for this entry: drop it and stop the job.
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        if (nonzero) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_ptr_q[ADDR_W-1:0];
                            mem_wdata_d = {col_q, in_weight};
                            wr_ptr_d    = wr_ptr_q + 1'b1;
                        end
                        if (in_last) begin
                            // Pointer reflects this beat's own write, if any.
                            ptr_we_d   = 1'b1;
                            ptr_addr_d = row_q;
                            ptr_data_d = wr_ptr_d;
                            col_d      = '0;
                            row_d      = row_q + 1'b1;
                            if (row_q == LAST_ROW) begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end else if (col_q == '1) begin
                            // Row is wider than the index field can encode.
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d  = S_PACK;
                    wr_ptr_d = '0;
                    col_d    = '0;
                    row_d    = '0;
                    err_d    = 1'b0;
                end
            end
        endcase
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ptr_we_q    <= 1'b0;
            ptr_addr_q  <= '0;
            ptr_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ptr_we_q    <= ptr_we_d;
            ptr_addr_q  <= ptr_addr_d;
            ptr_data_q  <= ptr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_csr_weight_packer.sv
// Testbench for csr_weight_packer: random and directed jobs checked against a
// list-based CSR model (running entry count, per-row cumulative pointers).
module tb_csr_weight_packer;

    localparam int AW    = 4;
    localparam int IW    = 3;
    localparam int WW    = 8;
    localparam int NR    = 4;
    localparam int RW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int COLS  = 1 << IW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [WW-1:0] in_weight = '0;
    logic in_ready;
    logic mem_we;
    logic [AW-1:0] mem_addr;
    logic [IW+WW-1:0] mem_wdata;
    logic ptr_we;
    logic [RW-1:0] ptr_addr;
    logic [AW:0] ptr_data;
    logic done;
    logic err;

    csr_weight_packer #(.ADDR_W(AW), .IDX_W(IW), .W_W(WW), .NUM_ROWS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_weight(in_weight), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ptr_we(ptr_we), .ptr_addr(ptr_addr), .ptr_data(ptr_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Job description (flat beat list) and expected results.
    logic [WW-1:0] bw[$];
    bit            bl[$];
    int exp_waddr[$], exp_wdata[$], exp_paddr[$], exp_pdata[$];
    int exp_acc;
    bit exp_done, exp_err;

    // Observed results.
    int got_waddr[$], got_wdata[$], got_paddr[$], got_pdata[$];
    int done_cnt, done_cyc;
    int drv_acc, drv_last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write and done pulse seen on the DUT outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                got_waddr.push_back(int'(mem_addr));
                got_wdata.push_back(int'(mem_wdata));
            end
            if (ptr_we) begin
                got_paddr.push_back(int'(ptr_addr));
                got_pdata.push_back(int'(ptr_data));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic clear_job();
        bw.delete(); bl.delete();
    endtask

    task automatic add_beat(input logic [WW-1:0] w, input bit last);
        bw.push_back(w); bl.push_back(last);
    endtask

    // Random row: each entry zero with probability zpct percent.
    task automatic add_rand_row(input int len, input int zpct, input bit last);
        for (int i = 0; i < len; i++) begin
            logic [WW-1:0] w;
            w = ($urandom_range(0, 99) < zpct) ? 8'd0 : 8'($urandom_range(1, 255));
            add_beat(w, last && (i == len - 1));
        end
    endtask

    // Reference: entries are numbered in arrival order; a row pointer is the
    // number of entries so far; faults end the job at the offending beat.
    task automatic build_model();
        int cnt, col, row;
        cnt = 0; col = 0; row = 0;
        exp_waddr.delete(); exp_wdata.delete(); exp_paddr.delete(); exp_pdata.delete();
        exp_acc = 0; exp_done = 0; exp_err = 0;
        for (int i = 0; i < bw.size(); i++) begin
            exp_acc++;
            if (bw[i] != 0) begin
                if (cnt == DEPTH) begin
                    exp_err = 1;
                    break;
                end
                exp_waddr.push_back(cnt);
                exp_wdata.push_back(col * (1 << WW) + int'(bw[i]));
                cnt++;
            end
            if (bl[i]) begin
                exp_paddr.push_back(row);
                exp_pdata.push_back(cnt);
                if (row == NR - 1) begin
                    exp_done = 1;
                    break;
                end
                row++;
                col = 0;
            end else if (col == COLS - 1) begin
                exp_err = 1;
                break;
            end else begin
                col++;
            end
        end
    endtask

    // Pulse start, then offer beats while in_ready; optional stall cycles
    // (with ignored start pulses) between beats.
    task automatic drive_job(input bit stall);
        int idx, guard;
        got_waddr.delete(); got_wdata.delete(); got_paddr.delete(); got_pdata.delete();
        done_cnt = 0; done_cyc = -1; drv_acc = 0; drv_last_cyc = -100;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        idx = 0; guard = 0;
        while (idx < bw.size() && guard < 1000) begin
            guard++;
            if (!in_ready) break;
            if (stall && (guard % 2 == 0)) begin
                in_valid = 1'b0;
                in_weight = 8'($urandom_range(1, 255));
                start = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                start = 1'b0;
                continue;
            end
            in_valid = 1'b1; in_weight = bw[idx]; in_last = bl[idx];
            drv_last_cyc = cyc;
            drv_acc++; idx++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; in_weight = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, ptr_we, ptr_addr, ptr_data, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got mem_we=%b addr=%0d wdata=%h ptr_we=%b paddr=%0d pdata=%0d done=%b err=%b, want all 0",
                     mem_we, mem_addr, mem_wdata, ptr_we, ptr_addr, ptr_data, done, err);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_ready: got %b want 0", in_ready);
        end
    endtask

    // Directed rows with hand-derived results: [0,5,0,-3] [0,0,0,0] [7] [0].
    task automatic test_spec_rows();
        int want_pdata[4];
        want_pdata = '{2, 2, 3, 3};
        clear_job();
        add_beat(8'd0, 0); add_beat(8'd5, 0); add_beat(8'd0, 0); add_beat(8'hFD, 1);
        add_beat(8'd0, 0); add_beat(8'd0, 0); add_beat(8'd0, 0); add_beat(8'd0, 1);
        add_beat(8'd7, 1);
        add_beat(8'd0, 1);
        drive_job(0);
        checks++;
        if (got_waddr.size() != 3 || got_paddr.size() != 4) begin
            errors++;
            $display("FAIL spec_counts: got %0d writes %0d ptrs, want 3 writes 4 ptrs",
                     got_waddr.size(), got_paddr.size());
        end else begin
            checks++;
            if (got_waddr[0] != 0 || got_wdata[0] != 'h105) begin
                errors++;
                $display("FAIL spec_write0: got addr %0d data %h, want addr 0 data 105", got_waddr[0], got_wdata[0]);
            end
            checks++;
            if (got_waddr[1] != 1 || got_wdata[1] != 'h3FD) begin
                errors++;
                $display("FAIL spec_write1: got addr %0d data %h, want addr 1 data 3fd", got_waddr[1], got_wdata[1]);
            end
            checks++;
            if (got_waddr[2] != 2 || got_wdata[2] != 'h007) begin
                errors++;
                $display("FAIL spec_write2: got addr %0d data %h, want addr 2 data 007", got_waddr[2], got_wdata[2]);
            end
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (got_paddr[r] != r || got_pdata[r] != want_pdata[r]) begin
                    errors++;
                    $display("FAIL spec_ptr%0d: got row %0d data %0d, want row %0d data %0d",
                             r, got_paddr[r], got_pdata[r], r, want_pdata[r]);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != drv_last_cyc + 1) begin
            errors++;
            $display("FAIL spec_done: got %0d pulses at cycle %0d, want 1 at cycle %0d",
                     done_cnt, done_cyc, drv_last_cyc + 1);
        end
        checks++;
        if (in_ready !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL spec_after_done: got in_ready=%b err=%b want 0 0", in_ready, err);
        end
    endtask

    task automatic test_random_stall();
        for (int it = 0; it < 6; it++) begin
            int nerr;
            clear_job();
            for (int r = 0; r < NR; r++) add_rand_row($urandom_range(1, 4), 45, 1);
            build_model();
            drive_job(1);
            nerr = 0;
            if (got_waddr.size() != exp_waddr.size() || got_paddr.size() != exp_paddr.size()) nerr++;
            for (int i = 0; i < exp_waddr.size() && i < got_waddr.size(); i++)
                if (got_waddr[i] != exp_waddr[i] || got_wdata[i] != exp_wdata[i]) nerr++;
            for (int i = 0; i < exp_paddr.size() && i < got_paddr.size(); i++)
                if (got_paddr[i] != exp_paddr[i] || got_pdata[i] != exp_pdata[i]) nerr++;
            checks++;
            if (nerr != 0) begin
                errors++;
                $display("FAIL random_image%0d: got %0d writes %0d ptrs (%0d bad entries), want %0d writes %0d ptrs",
                         it, got_waddr.size(), got_paddr.size(), nerr, exp_waddr.size(), exp_paddr.size());
            end
            checks++;
            if (done_cnt != 1 || done_cyc != drv_last_cyc + 1 || err !== 1'b0 || drv_acc != exp_acc) begin
                errors++;
                $display("FAIL random_done%0d: got done=%0d@%0d err=%b acc=%0d, want done=1@%0d err=0 acc=%0d",
                         it, done_cnt, done_cyc, err, drv_acc, drv_last_cyc + 1, exp_acc);
            end
        end
    endtask

    // Two full rows fill all 16 entries; zeros still pass, next nonzero faults.
    task automatic test_full();
        clear_job();
        add_rand_row(COLS, 0, 1);
        add_rand_row(COLS, 0, 1);
        add_beat(8'd0, 0); add_beat(8'd0, 0); add_beat(8'd9, 0); add_beat(8'd4, 1);
        build_model();
        drive_job(0);
        checks++;
        if (got_waddr.size() != DEPTH || exp_waddr.size() != DEPTH) begin
            errors++;
            $display("FAIL full_writes: got %0d want %0d", got_waddr.size(), DEPTH);
        end
        checks++;
        if (got_pdata.size() != 2 || got_pdata[1] != DEPTH) begin
            errors++;
            $display("FAIL full_ptr: got %0d ptrs last=%0d, want 2 ptrs last=%0d",
                     got_pdata.size(), (got_pdata.size() > 0) ? got_pdata[got_pdata.size()-1] : -1, DEPTH);
        end
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || done_cnt != 0 || drv_acc != exp_acc) begin
            errors++;
            $display("FAIL full_err: got err=%b in_ready=%b done=%0d acc=%0d, want 1 0 0 %0d",
                     err, in_ready, done_cnt, drv_acc, exp_acc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    // A start after a fault must clear err before the next job packs.
    task automatic test_restart_clears_err();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart: got err=%b in_ready=%b want 0 1", err, in_ready);
        end
    endtask

    // Row wider than the column field: the beat at the top column is still written.
    task automatic test_col_overflow();
        clear_job();
        add_rand_row(COLS + 2, 0, 0);
        build_model();
        drive_job(0);
        checks++;
        if (got_waddr.size() != COLS || got_wdata.size() != COLS ||
            got_wdata[COLS-1] != exp_wdata[COLS-1]) begin
            errors++;
            $display("FAIL colovf_writes: got %0d writes, want %0d ending with %h",
                     got_waddr.size(), COLS, exp_wdata[COLS-1]);
        end
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || drv_acc != COLS || got_paddr.size() != 0) begin
            errors++;
            $display("FAIL colovf_err: got err=%b in_ready=%b acc=%0d ptrs=%0d, want 1 0 %0d 0",
                     err, in_ready, drv_acc, got_paddr.size(), COLS);
        end
    endtask

    task automatic test_reset_midjob();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; in_last = 1'b0; in_weight = 8'd11;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, ptr_we, ptr_addr, ptr_data, done, err, in_ready} !== '0) begin
            errors++;
            $display("FAIL midjob_reset: got mem_we=%b addr=%0d ptr_we=%b done=%b err=%b in_ready=%b, want all 0",
                     mem_we, mem_addr, ptr_we, done, err, in_ready);
        end
        in_valid = 1'b0; in_weight = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Consecutive jobs with no gap, each must restart the image at address 0.
    task automatic test_back_to_back();
        for (int it = 0; it < 2; it++) begin
            int nerr;
            clear_job();
            for (int r = 0; r < NR; r++) add_rand_row($urandom_range(1, 3), 30, 1);
            build_model();
            drive_job(0);
            nerr = 0;
            if (got_waddr.size() != exp_waddr.size() || got_pdata.size() != exp_pdata.size()) nerr++;
            for (int i = 0; i < exp_waddr.size() && i < got_waddr.size(); i++)
                if (got_waddr[i] != exp_waddr[i] || got_wdata[i] != exp_wdata[i]) nerr++;
            for (int i = 0; i < exp_pdata.size() && i < got_pdata.size(); i++)
                if (got_pdata[i] != exp_pdata[i]) nerr++;
            checks++;
            if (nerr != 0 || done_cnt != 1 || err !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d: got %0d writes (%0d bad) done=%0d err=%b, want %0d writes done=1 err=0",
                         it, got_waddr.size(), nerr, done_cnt, err, exp_waddr.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_rows();
        test_random_stall();
        test_full();
        test_restart_clears_err();
        test_col_overflow();
        test_reset_midjob();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
